// File: rtl/ram_sync_dp_be.sv
// Simple-dual-port sync RAM with byte enables, write-first forwarding,
// registered read with valid strobe, and a post-reset zero-clear sweep.
//
// Ports: clock, reset_n (async, active low);
//   wr_en/wr_addr/wr_data/wr_be : write port;
//   rd_en/rd_addr -> rd_data/rd_valid : read port;
//   init_busy : high while the clear sweep runs.
// Define RAM_OUT_REG_EN for an extra output register stage (latency 2).
module ram_sync_dp_be #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic [DWIDTH-1:0]     wr_data,
  input  logic [DWIDTH/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [AWIDTH-1:0]     rd_addr,
  output logic [DWIDTH-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  init_busy
);

  localparam int DEPTH  = 1 << AWIDTH;
  localparam int NBYTES = DWIDTH / 8;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t              state;
  logic [AWIDTH-1:0]   cnt;
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic                run;
  logic                wr_go;
  logic                rd_go;
  logic                hit;
  logic [DWIDTH-1:0]   rd_word;
  logic [DWIDTH-1:0]   rd_data_a;
  logic                rd_valid_a;

  assign run       = (state == RUN);
  assign wr_go     = run & wr_en;
  assign rd_go     = run & rd_en;
  assign hit       = wr_go & (wr_addr == rd_addr);
  assign init_busy = ~run;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + AWIDTH'(1);
          if (cnt == AWIDTH'(DEPTH - 1))
            state <= RUN;
        end
        RUN: state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  // Array has no reset; the sweep zeroes it one word per cycle.
  always_ff @(posedge clock) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NBYTES; i++)
        if (wr_be[i])
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Write-first: enabled bytes of a colliding write replace old data.
  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < NBYTES; i++)
      if (hit && wr_be[i])
        rd_word[8*i +: 8] = wr_data[8*i +: 8];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
    end else begin
      rd_valid_a <= rd_go;
      if (rd_go)
        rd_data_a <= rd_word;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DWIDTH-1:0] rd_data_b;
  logic              rd_valid_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
    end else begin
      rd_valid_b <= rd_valid_a;
      if (rd_valid_a)
        rd_data_b <= rd_data_a;
    end
  end

  assign rd_data  = rd_data_b;
  assign rd_valid = rd_valid_b;
`else
  assign rd_data  = rd_data_a;
  assign rd_valid = rd_valid_a;
`endif

endmodule

// File: tb/tb_ram_sync_dp_be.sv
// Directed + scoreboard bench for ram_sync_dp_be (AWIDTH=3, DWIDTH=32).
// Expected read data is queued at request time and popped on rd_valid.
module tb_ram_sync_dp_be;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        init_busy;

  always #5 clock = ~clock;

  ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .init_busy (init_busy)
  );

  int          vectors = 0;
  int          errs    = 0;
  logic [31:0] model [8];
  logic [31:0] q [$];
  logic [LAT-1:0] vp;
  logic        run_m;
  int          cnt_m;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    rd_en = 0; rd_addr = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  // One clock: predict, advance, then check outputs 1 time unit later.
  task automatic cyc(string tag);
    logic        acc;
    logic        ev;
    logic [31:0] e;
    acc = reset_n && run_m;
    ev  = acc && rd_en;
    if (ev) begin
      e = model[rd_addr];
      if (wr_en && wr_addr == rd_addr)
        for (int i = 0; i < 4; i++)
          if (wr_be[i]) e[8*i +: 8] = wr_data[8*i +: 8];
      q.push_back(e);
    end
    if (acc && wr_en)
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) model[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
    if (!reset_n) begin
      run_m = 0; cnt_m = 0; vp = '0; q.delete();
    end else begin
      if (!run_m) begin
        cnt_m++;
        if (cnt_m == 8) run_m = 1;
      end
      vp = LAT'({vp, ev});
    end
    @(posedge clock);
    #1;
    chk({tag, ".busy"}, 32'(init_busy), 32'(!run_m));
    chk({tag, ".vld"}, 32'(rd_valid), 32'(vp[LAT-1]));
    if (vp[LAT-1] && rd_valid === 1'b1) begin
      if (q.size() == 0) chk({tag, ".qempty"}, 32'(1), 32'(0));
      else chk({tag, ".data"}, rd_data, q.pop_front());
    end
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d, logic [3:0] be);
    idle();
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
    cyc("wr");
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < LAT + 1; i++) cyc("drain");
  endtask

  initial begin
    idle();
    reset_n = 0;
    run_m = 0; cnt_m = 0; vp = '0;
    clear_model();
    #1;
    chk("rst.data", rd_data, 32'h0);
    chk("rst.vld", 32'(rd_valid), 32'h0);
    chk("rst.busy", 32'(init_busy), 32'h1);
    cyc("rst");
    cyc("rst");
    reset_n = 1;

    // Requests during the sweep must be ignored.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
      rd_en = 1; rd_addr = 3'(i);
      cyc("init");
    end
    idle();

    for (int i = 0; i < 8; i++) begin
      rd_en = 1; rd_addr = 3'(i);
      cyc("zero");
    end
    drain();

    wr(3'd5, 32'hDEAD_BEEF, 4'b1111);
    wr(3'd5, 32'h1122_3344, 4'b0101);
    idle(); rd_en = 1; rd_addr = 3'd5;
    cyc("be");
    drain();
    chk("be.model", model[5], 32'hDE22_BE44);

    wr(3'd2, 32'h1234_5678, 4'b1111);
    wr(3'd2, 32'h0000_0000, 4'b0000);
    idle();
    wr_en = 1; wr_addr = 3'd2; wr_data = 32'hCAFE_F00D; wr_be = 4'b1100;
    rd_en = 1; rd_addr = 3'd2;
    cyc("fwd");
    drain();
    chk("fwd.model", model[2], 32'hCAFE_5678);

    for (int i = 0; i < 4; i++) wr(3'(i), 32'hA0 + 32'(i), 4'hF);
    idle();
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_addr = 3'(i);
      cyc("b2b");
    end
    drain();

    for (int i = 0; i < 24; i++) begin
      wr_en   = 1'($urandom);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = $urandom;
      wr_be   = 4'($urandom);
      rd_en   = 1'($urandom_range(0, 3) != 0);
      rd_addr = (i % 3 == 0) ? wr_addr : 3'($urandom_range(0, 7));
      cyc("rnd");
    end
    drain();

    // Reset in the middle of a read burst.
    idle();
    for (int i = 0; i < 3; i++) begin
      rd_en = 1; rd_addr = 3'd5;
      cyc("burst");
    end
    #2;
    reset_n = 0;
    #1;
    chk("mid.vld", 32'(rd_valid), 32'h0);
    chk("mid.data", rd_data, 32'h0);
    chk("mid.busy", 32'(init_busy), 32'h1);
    clear_model();
    cyc("mid");
    reset_n = 1;
    idle();
    for (int i = 0; i < 8; i++) cyc("resweep");
    for (int i = 0; i < 8; i++) begin
      rd_en = 1; rd_addr = 3'(i);
      cyc("clr");
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_sync_dp_be.md
# ram_sync_dp_be

Parametrised simple-dual-port synchronous RAM: the next generation of the single-port sync-read data RAMs in the datapath. It has independent write and read ports, per-byte write enables, a registered read with a valid strobe, write-first forwarding on address collision, and a post-reset hardware clear sweep, so contents are deterministic without file preloading. It sits between the datapath engines and their local scratch storage.

## Interface
- AWIDTH, 3, address width; DEPTH = 1 << AWIDTH (derived, not overridable)
- DWIDTH, 32, data width; must be a multiple of 8; NBYTES = DWIDTH/8 (derived)
- clock  in  1  sole clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request, sampled at posedge
- wr_addr  in  AWIDTH  write address
- wr_data  in  DWIDTH  write data
- wr_be  in  NBYTES  byte enables; bit i enables wr_data[8i+7:8i]
- rd_en  in  1  read request, sampled at posedge
- rd_addr  in  AWIDTH  read address
- rd_data  out  DWIDTH  read data; holds last value when rd_valid=0
- rd_valid  out  1  one-cycle strobe marking rd_data valid
- init_busy  out  1  high while clear sweep runs; requests ignored

## Operation
- FSM states: INIT, RUN. Reset asserted -> INIT, clear counter = 0.
- INIT: each cycle write all-zero to mem[counter], counter += 1; on counter = DEPTH-1 write then go RUN. Sweep takes exactly DEPTH cycles. init_busy = 1 in INIT, 0 in RUN.
- In INIT, wr_en and rd_en are ignored (no write, no rd_valid).
- RUN write: wr_en=1 -> for every i with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i; other bytes unchanged. wr_be = 0 is a legal no-op.
- RUN read: rd_en=1 -> rd_data <= mem[rd_addr]; rd_valid asserts on the following cycle for one cycle per accepted request. Back-to-back reads every cycle supported.
- Collision (wr_en & rd_en & wr_addr == rd_addr, same cycle): write-first; rd_data returns enabled bytes from wr_data, disabled bytes from old memory contents.
- Reset mid-operation: any in-flight read is dropped (rd_valid forced 0), FSM restarts INIT at counter 0; a write sampled on the same edge as reset assertion is lost.
- No address range check needed: AWIDTH covers DEPTH exactly; counter wraps only via state exit.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, init_busy = 1 (asserted during and after reset until sweep completes).
- First cycle of RUN: first edge at which requests are accepted is the edge where init_busy is sampled 0.
- Read latency: 1 cycle (request edge N, data/valid after edge N+1 visible in cycle N+1) without output register; 2 with it.
- Write latency: written data readable by a read issued the next cycle; same-cycle via forwarding.
- Throughput: one write and one read per cycle, concurrently.

## Configuration
- RAM_OUT_REG_EN defined: adds one output register stage after the array read; rd_data and rd_valid delayed by one extra cycle (latency 2), still full throughput; forwarding result passes through the same stage; the stage resets to 0.
- Undefined: latency 1 as above, no extra stage.

## Test plan
- Reset release with AWIDTH=3 -> init_busy high 8 cycles, then 0; reads of addr 0..7 all return 0x00000000 with rd_valid one cycle after each rd_en.
- Write 0xDEADBEEF to addr 5 wr_be=4'b1111, next cycle write 0x11223344 to addr 5 wr_be=4'b0101, then read addr 5 -> 0xDE22BE44.
- Same cycle write 0xCAFEF00D be=4'b1100 and read addr 2 (old 0x12345678) -> rd_data 0xCAFE5678 next cycle.
- rd_en held high 4 cycles over addr 0,1,2,3 with preloaded 0xA0..0xA3 -> rd_valid high 4 consecutive cycles, data 0xA0,0xA1,0xA2,0xA3 in order; with RAM_OUT_REG_EN same sequence shifted one cycle.
- wr_en/rd_en pulsed during INIT -> no rd_valid, memory remains all-zero after sweep.
- Assert reset_n low during a read burst -> rd_valid and rd_data drop to 0 immediately, init_busy 1, sweep restarts and clears previously written data.
